// File: rtl/audio_codec_serdes_if.sv
// Codec-side audio serial bus: DAC/ADC sample words, serial lines
// and frame strobes between the filter chain and the serdes.
interface audio_codec_serdes_if;
    logic [15:0] dac_left_in;
    logic [15:0] dac_right_in;
    logic        adc_dat;
    logic        bclk;
    logic        lr_clk;
    logic        dac_dat;
    logic [15:0] adc_left_out;
    logic [15:0] adc_right_out;
    logic        adc_valid;
    logic        dac_load;

    modport master (
        input  dac_left_in,
        input  dac_right_in,
        input  adc_dat,
        output bclk,
        output lr_clk,
        output dac_dat,
        output adc_left_out,
        output adc_right_out,
        output adc_valid,
        output dac_load
    );

    modport slave (
        output dac_left_in,
        output dac_right_in,
        output adc_dat,
        input  bclk,
        input  lr_clk,
        input  dac_dat,
        input  adc_left_out,
        input  adc_right_out,
        input  adc_valid,
        input  dac_load
    );
endinterface

// File: rtl/audio_codec_serdes.sv
// Left-justified 2x16-bit audio serdes: bclk/lr_clk generation,
// DAC serialisation on bclk falls, ADC capture on bclk rises.
module audio_codec_serdes #(
    parameter int BCLK_DIV = 4
) (
    input logic                  state_clk,
    input logic                  reset,
    audio_codec_serdes_if.master bus
);
    localparam int DW = $clog2(BCLK_DIV);

    logic [DW-1:0] divcnt_q;
    logic          bclk_q;
    logic          lr_q;
    logic          dac_dat_q;
    logic          adc_valid_q;
    logic          dac_load_q;
    logic [4:0]    bit_cnt_q;
    logic [15:0]   dac_l_sr_q;
    logic [15:0]   dac_r_sr_q;
    logic [15:0]   adc_sr_q;
    logic [15:0]   adc_l_q;
    logic [15:0]   adc_r_q;

    logic          tick;
    logic [4:0]    bit_cnt_d;
    logic [3:0]    idx_l;
    logic [3:0]    idx_r;
    logic          dac_bit_d;
    logic [15:0]   adc_sr_d;

    // Next slot bit index, the DAC bit it selects, and the ADC shift value
    always_comb begin
        tick      = (divcnt_q == DW'(BCLK_DIV - 1));
        bit_cnt_d = bit_cnt_q + 5'd1;
        idx_l     = 4'(5'd15 - bit_cnt_d);
        idx_r     = 4'(5'd31 - bit_cnt_d);
        dac_bit_d = bit_cnt_d[4] ? dac_r_sr_q[idx_r] : dac_l_sr_q[idx_l];
        if (bit_cnt_d == 5'd0) begin
            dac_bit_d = bus.dac_left_in[15];
        end
        adc_sr_d  = {adc_sr_q[14:0], bus.adc_dat};
    end

    // Divider, bit clock, DAC shift-out on falls, ADC capture on rises
    always_ff @(posedge state_clk or negedge reset) begin
        if (!reset) begin
            divcnt_q    <= '0;
            bclk_q      <= 1'b1;
            bit_cnt_q   <= 5'd31;
            lr_q        <= 1'b1;
            dac_dat_q   <= 1'b0;
            dac_l_sr_q  <= '0;
            dac_r_sr_q  <= '0;
            adc_sr_q    <= '0;
            adc_l_q     <= '0;
            adc_r_q     <= '0;
            adc_valid_q <= 1'b0;
            dac_load_q  <= 1'b0;
        end else begin
            adc_valid_q <= 1'b0;
            dac_load_q  <= 1'b0;
            if (tick) begin
                divcnt_q <= '0;
                bclk_q   <= ~bclk_q;
                if (bclk_q) begin
                    bit_cnt_q <= bit_cnt_d;
                    lr_q      <= bit_cnt_d[4];
                    dac_dat_q <= dac_bit_d;
                    if (bit_cnt_d == 5'd0) begin
                        dac_l_sr_q <= bus.dac_left_in;
                        dac_r_sr_q <= bus.dac_right_in;
                        dac_load_q <= 1'b1;
                    end
                end else begin
                    adc_sr_q <= adc_sr_d;
                    if (bit_cnt_q == 5'd15) begin
                        adc_l_q <= adc_sr_d;
                    end
                    if (bit_cnt_q == 5'd31) begin
                        adc_r_q     <= adc_sr_d;
                        adc_valid_q <= 1'b1;
                    end
                end
            end else begin
                divcnt_q <= divcnt_q + DW'(1);
            end
        end
    end

    assign bus.bclk          = bclk_q;
    assign bus.lr_clk        = lr_q;
    assign bus.dac_dat       = dac_dat_q;
    assign bus.adc_left_out  = adc_l_q;
    assign bus.adc_right_out = adc_r_q;
    assign bus.adc_valid     = adc_valid_q;
    assign bus.dac_load      = dac_load_q;
endmodule

// File: tb/tb_audio_codec_serdes.sv
// Bench for audio_codec_serdes: per-frame vector table, codec model,
// arithmetic timing model, loopback and mid-frame reset.
module tb_audio_codec_serdes;
    localparam int B  = 4;
    localparam int NV = 12;

    typedef struct {
        logic [15:0] dl;
        logic [15:0] dr;
        logic [15:0] al;
        logic [15:0] ar;
        bit          loop;
        logic [31:0] exp_dac;
        logic [15:0] exp_al;
        logic [15:0] exp_ar;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   n;
    int   vp;
    bit   fell20;
    vec_t vec[NV];
    vec_t applied;
    vec_t cur;
    logic [31:0] rx;
    logic [31:0] word;

    audio_codec_serdes_if bus ();

    audio_codec_serdes #(.BCLK_DIV(B)) dut (
        .state_clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic [15:0] dl, logic [15:0] dr,
                                logic [15:0] al, logic [15:0] ar,
                                bit loop);
        vec_t v;
        v.dl = dl;
        v.dr = dr;
        v.al = al;
        v.ar = ar;
        v.loop = loop;
        v.exp_dac = {dl, dr};
        v.exp_al = loop ? dl : al;
        v.exp_ar = loop ? dr : ar;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        applied = v;
        bus.dac_left_in = v.dl;
        bus.dac_right_in = v.dr;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_bclk_lr"}, {30'd0, bus.bclk, bus.lr_clk}, 32'd3);
        chk({tag, "_dat_pulses"}, {29'd0, bus.dac_dat, bus.dac_load, bus.adc_valid}, 32'd0);
        chk({tag, "_adc_words"}, {bus.adc_left_out, bus.adc_right_out}, 32'd0);
    endtask

    // One state_clk cycle: sample after the edge and compare against
    // the frame-timing arithmetic and the per-frame word expectations.
    task automatic step();
        int tg, f, r, b;
        bit edge_c, fall, rise;
        logic ebclk, elr, eload, evalid;
        @(posedge clk);
        #1;
        n++;
        tg = n / B;
        edge_c = (n % B) == 0;
        f = (tg + 1) / 2;
        r = tg / 2;
        fall = edge_c && (tg % 2 == 1);
        rise = edge_c && tg > 0 && (tg % 2 == 0);
        b = fall ? (f - 1) % 32 : (rise ? (r - 1) % 32 : 0);
        ebclk = (tg % 2) == 0;
        elr = (f == 0) ? 1'b1 : ((f - 1) % 32 >= 16);
        eload = fall && b == 0;
        evalid = rise && b == 31;
        chk("timing", {28'd0, bus.bclk, bus.lr_clk, bus.dac_load, bus.adc_valid},
            {28'd0, ebclk, elr, eload, evalid});
        if (fall) begin
            if (b == 0) begin
                cur = applied;
                rx = '0;
            end
            rx = {rx[30:0], bus.dac_dat};
            if (b == 5 && vp < NV) begin
                apply(vec[vp]);
                vp++;
            end
            if (b == 31) chk("dac_word", rx, cur.exp_dac);
            if (b == 20) fell20 = 1'b1;
            word = {cur.al, cur.ar};
            bus.adc_dat = cur.loop ? bus.dac_dat : word[31 - b];
        end
        if (rise && b == 15) chk("adc_left_mid", {16'd0, bus.adc_left_out}, {16'd0, cur.exp_al});
        if (rise && b == 31) begin
            chk("adc_left", {16'd0, bus.adc_left_out}, {16'd0, cur.exp_al});
            chk("adc_right", {16'd0, bus.adc_right_out}, {16'd0, cur.exp_ar});
        end
    endtask

    initial begin
        int guard;
        errors = 0;
        checks = 0;
        n = 0;
        vp = 1;
        fell20 = 1'b0;
        rx = '0;
        vec[0] = mk(16'hA5C3, 16'h8001, 16'h1234, 16'hFEDC, 1'b0);
        vec[1] = mk(16'h0000, 16'h5555, 16'h8000, 16'h0001, 1'b0);
        vec[2] = mk(16'h7FFF, 16'h0000, 16'hFFFF, 16'h7FFF, 1'b0);
        vec[3] = mk(16'hBEEF, 16'h0F0F, 16'h0000, 16'h0000, 1'b1);
        vec[4] = mk(16'hA5C3, 16'h8001, 16'h1234, 16'hFEDC, 1'b0);
        for (int i = 5; i < NV; i++) begin
            vec[i] = mk(16'($urandom), 16'($urandom), 16'($urandom),
                        16'($urandom), 1'($urandom_range(0, 1)));
        end
        cur = vec[0];
        rst_n = 1'b0;
        bus.adc_dat = 1'b0;
        apply(vec[0]);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;

        repeat (6 * 64 * B + 2 * B) step();

        guard = 0;
        while (!fell20 && guard < 400) begin
            step();
            guard++;
        end
        chk("reach_bit20", {31'd0, fell20}, 32'd1);
        repeat (3) step();
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk_reset("held_reset");
        bus.adc_dat = 1'b0;
        rst_n = 1'b1;
        n = 0;

        repeat (3 * 64 * B + 2 * B) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/audio_codec_serdes.md
Name: audio_codec_serdes

Overview:
- Codec-side audio serial interface for the filter chain: generates bclk and lr_clk, serialises left/right 16-bit 2's-complement DAC samples, and deserialises ADC samples from the codec.
- Runs on the same fast state_clk as the filter state machines. lr_clk from this block is the frame strobe the filters one-shot on.
- The ADC outputs feed the filter audio_in; the filter audio_out feeds the DAC inputs.
- Format is left-justified: MSB first, 16 data bits per slot, 32 bclk per frame.

Parameters:
- BCLK_DIV, 4, state_clk cycles per bclk half-period; legal range is 2 or more. bclk period = 2*BCLK_DIV cycles; frame = 64*BCLK_DIV cycles.

Ports:
- state_clk  input  1  sole clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- dac_left_in  input  16  left DAC sample, 2's complement; sampled at frame start only.
- dac_right_in  input  16  right DAC sample, 2's complement; sampled at frame start only.
- adc_dat  input  1  serial ADC data from codec; codec changes it after bclk falling edges.
- bclk  output  1  bit clock to codec.
- lr_clk  output  1  frame clock: 0 = left slot, 1 = right slot.
- dac_dat  output  1  serial DAC data to codec.
- adc_left_out  output  16  last complete left ADC sample.
- adc_right_out  output  16  last complete right ADC sample.
- adc_valid  output  1  one-cycle pulse: both ADC words updated.
- dac_load  output  1  one-cycle pulse: DAC inputs latched.

Behaviour:
- Reset values (while reset=0): divcnt=0, bclk=1, bit_cnt=31, lr_clk=1, dac_dat=0, shift registers=0, adc_left_out=0, adc_right_out=0, adc_valid=0, dac_load=0.
- Assertion mid-frame aborts immediately. After release, the first falling edge starts a clean frame 0.
- Divider: divcnt increments each cycle. When divcnt==BCLK_DIV-1: divcnt<=0 and bclk<=~bclk (the toggle cycle). The first toggle occurs BCLK_DIV cycles after reset release and is a fall.
- All outputs are registered. dac_dat and lr_clk change on the same state_clk edge that drops bclk.
- Falling toggle:
  - bit_cnt<=bit_cnt+1 mod 32.
  - lr_clk<=new bit_cnt[4].
  - New bit_cnt==0: latch dac_left_in into dac_l_sr and dac_right_in into dac_r_sr; dac_dat<=dac_left_in[15]; dac_load=1 for that cycle.
  - New bit_cnt 1..15: dac_dat<=dac_l_sr[15-bit_cnt].
  - New bit_cnt 16..31: dac_dat<=dac_r_sr[31-bit_cnt].
  - The right MSB is therefore coincident with lr_clk rising; the left MSB with lr_clk falling.
- Rising toggle:
  - adc_sr<={adc_sr[14:0],adc_dat}.
  - bit_cnt==15: adc_left_out<={adc_sr[14:0],adc_dat}.
  - bit_cnt==31: adc_right_out<={adc_sr[14:0],adc_dat}; adc_valid=1 for that cycle.
  - The ADC words are stable from then until the next capture.
- Input timing: DAC inputs may change at any time; only the frame-start value is used. A change mid-frame takes effect at the next frame.
- No rising-edge capture occurs between reset release and the first fall. The first adc_valid therefore reports a full frame 0 with no stale bits.
- adc_valid and dac_load are never asserted in the same cycle: they are separated by bclk half-periods.

Test Plan:
- Reset, BCLK_DIV=4 -> bclk=1, lr_clk=1, outputs 0. First bclk fall 4 cycles after release, with lr_clk=0 and dac_load=1 in that same cycle. bclk period is 8 cycles; lr_clk period is 256 cycles.
- dac_left_in=16'hA5C3, dac_right_in=16'h8001 held -> per frame, dac_dat at successive falls = A5C3 bits MSB-first, then 8001 bits MSB-first. Right MSB=1 coincides with lr_clk rising.
- Codec model drives adc_dat on bclk falls with left=16'h1234, right=16'hFEDC -> after the 16th left rise, adc_left_out=16'h1234. After the 32nd rise, adc_right_out=16'hFEDC with a single-cycle adc_valid; repeats every 256 cycles.
- dac_left_in changed 16'h0000→16'h7FFF at bit_cnt=5 -> current frame continues 0000 bits; next frame serialises 7FFF.
- Loopback dac_dat→adc_dat with dac_left_in=16'hBEEF, dac_right_in=16'h0F0F -> adc_left_out=16'hBEEF, adc_right_out=16'h0F0F (same frame).
- Reset asserted at bit_cnt=20 -> all outputs return to reset values asynchronously. After release, a full frame yields correct words with no partial-frame adc_valid.
